// File: rtl/pusch_pingpong_reader_if.sv
// rtl/pusch_pingpong_reader_if.sv - buffer-read, bank-control and symbol-stream bundle of the PUSCH ping-pong reader
interface pusch_pingpong_reader_if #(
  parameter int LUT_WIDTH  = 18,
  parameter int ADDR_WIDTH = 11
);
  // writer side: frame-complete descriptor
  logic                         Switch_In;
  logic [ADDR_WIDTH-1:0]        Sym_Count_In;
  // symbol buffer read port
  logic signed [LUT_WIDTH-1:0]  Rd_Data_I;
  logic signed [LUT_WIDTH-1:0]  Rd_Data_Q;
  logic                         Rd_En;
  logic [ADDR_WIDTH-1:0]        Rd_Addr;
  // bank arbitration
  logic                         Wr_Bank;
  logic                         Rd_Bank;
  // output symbol stream
  logic signed [LUT_WIDTH-1:0]  Out_I;
  logic signed [LUT_WIDTH-1:0]  Out_Q;
  logic                         Out_Valid;
  logic                         Out_Ready;
  logic                         Out_First;
  logic                         Out_Last;
  // status
  logic                         Busy;
  logic                         Overrun;

  // the reader drives bank control, the read port and the stream
  modport master (
    input  Switch_In, Sym_Count_In, Rd_Data_I, Rd_Data_Q, Out_Ready,
    output Wr_Bank, Rd_Bank, Rd_En, Rd_Addr,
    output Out_I, Out_Q, Out_Valid, Out_First, Out_Last, Busy, Overrun
  );

  // the environment: writer, buffer and downstream consumer
  modport slave (
    output Switch_In, Sym_Count_In, Rd_Data_I, Rd_Data_Q, Out_Ready,
    input  Wr_Bank, Rd_Bank, Rd_En, Rd_Addr,
    input  Out_I, Out_Q, Out_Valid, Out_First, Out_Last, Busy, Overrun
  );
endinterface

// File: rtl/pusch_pingpong_reader.sv
// rtl/pusch_pingpong_reader.sv - reads a completed PUSCH frame from the idle bank and streams it with valid/ready
module pusch_pingpong_reader #(
  parameter int LUT_WIDTH  = 18,
  parameter int ADDR_WIDTH = 11,
  parameter int MAX_SYM    = 1200
) (
  input  logic                    CLK_PP,
  input  logic                    RST_PP,
  pusch_pingpong_reader_if.master pp
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] MAX_N = ADDR_WIDTH'(MAX_SYM);

  // control state
  logic [1:0]            r_state;
  logic                  r_wr_bank;
  logic                  r_rd_bank;
  logic [ADDR_WIDTH-1:0] r_n;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_overrun;

  // read issued last cycle; its data is on Rd_Data this cycle
  logic                  r_pend;
  logic                  r_pend_first;
  logic                  r_pend_last;

  // 2-entry output skid FIFO
  logic signed [LUT_WIDTH-1:0] r_fifo_i [2];
  logic signed [LUT_WIDTH-1:0] r_fifo_q [2];
  logic                        r_fifo_first [2];
  logic                        r_fifo_last [2];
  logic                        r_wr_ptr;
  logic                        r_rd_ptr;
  logic [1:0]                  r_cnt;

  logic                  w_busy;
  logic                  w_out_valid;
  logic                  w_pop;
  logic                  w_last_hs;
  logic [ADDR_WIDTH-1:0] w_sym_n;
  logic                  w_accept;
  logic                  w_start;
  logic                  w_overrun_ev;
  logic [1:0]            w_cnt_eff;
  logic [1:0]            w_occ;
  logic                  w_issue;
  logic                  w_issue_last;

  assign w_busy      = (r_state != S_IDLE);
  assign w_out_valid = (r_cnt != 2'd0);
  assign w_pop       = w_out_valid & pp.Out_Ready;

  // the final symbol leaving the FIFO frees the reader for the next frame in the same cycle
  assign w_last_hs   = w_pop & r_fifo_last[r_rd_ptr] & (r_state == S_DRAIN);

  assign w_sym_n      = (pp.Sym_Count_In > MAX_N) ? MAX_N : pp.Sym_Count_In;
  assign w_accept     = pp.Switch_In & (~w_busy | w_last_hs);
  assign w_start      = w_accept & (w_sym_n != '0);
  assign w_overrun_ev = pp.Switch_In & w_busy & ~w_last_hs;

  // A slot being popped this cycle is free by the time a new read's data lands,
  // which is what lets a 2-entry FIFO sustain one symbol per cycle.
  assign w_cnt_eff    = r_cnt - {1'b0, w_pop};
  assign w_occ        = w_cnt_eff + {1'b0, r_pend};
  assign w_issue      = (r_state == S_READ) & (w_occ < 2'd2);
  assign w_issue_last = w_issue & (r_addr == (r_n - 1'b1));

  // frame FSM: IDLE -> READ -> DRAIN -> IDLE, or straight back to READ on a back-to-back frame
  always_ff @(posedge CLK_PP) begin
    if (RST_PP) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) r_state <= S_READ;
        end
        S_READ: begin
          if (w_issue_last) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_last_hs) r_state <= w_start ? S_READ : S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // bank arbitration: writer bank flips on every switch, read bank follows only on an accepted frame
  always_ff @(posedge CLK_PP) begin
    if (RST_PP) begin
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_n       <= '0;
    end else begin
      if (pp.Switch_In) r_wr_bank <= ~r_wr_bank;
      if (w_start) begin
        r_rd_bank <= r_wr_bank;
        r_n       <= w_sym_n;
      end
    end
  end

  // read address: restart at 0 per frame, stop on N-1 so it never wraps or overshoots
  always_ff @(posedge CLK_PP) begin
    if (RST_PP) begin
      r_addr <= '0;
    end else if (w_start) begin
      r_addr <= '0;
    end else if (w_issue & ~w_issue_last) begin
      r_addr <= r_addr + 1'b1;
    end
  end

  // sticky overrun on a descriptor that arrives while a frame is still in progress
  always_ff @(posedge CLK_PP) begin
    if (RST_PP) begin
      r_overrun <= 1'b0;
    end else if (w_overrun_ev) begin
      r_overrun <= 1'b1;
    end
  end

  // carry first/last tags alongside the in-flight read so they meet their data at the FIFO
  always_ff @(posedge CLK_PP) begin
    if (RST_PP) begin
      r_pend       <= 1'b0;
      r_pend_first <= 1'b0;
      r_pend_last  <= 1'b0;
    end else begin
      r_pend       <= w_issue;
      r_pend_first <= w_issue & (r_addr == '0);
      r_pend_last  <= w_issue_last;
    end
  end

  // skid FIFO: capture buffer data one cycle after the read, pop on handshake
  always_ff @(posedge CLK_PP) begin
    if (RST_PP) begin
      r_fifo_i[0]     <= '0;
      r_fifo_i[1]     <= '0;
      r_fifo_q[0]     <= '0;
      r_fifo_q[1]     <= '0;
      r_fifo_first[0] <= 1'b0;
      r_fifo_first[1] <= 1'b0;
      r_fifo_last[0]  <= 1'b0;
      r_fifo_last[1]  <= 1'b0;
      r_wr_ptr        <= 1'b0;
      r_rd_ptr        <= 1'b0;
      r_cnt           <= 2'd0;
    end else begin
      if (r_pend) begin
        r_fifo_i[r_wr_ptr]     <= pp.Rd_Data_I;
        r_fifo_q[r_wr_ptr]     <= pp.Rd_Data_Q;
        r_fifo_first[r_wr_ptr] <= r_pend_first;
        r_fifo_last[r_wr_ptr]  <= r_pend_last;
        r_wr_ptr               <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_cnt <= r_cnt + {1'b0, r_pend} - {1'b0, w_pop};
    end
  end

  assign pp.Wr_Bank   = r_wr_bank;
  assign pp.Rd_Bank   = r_rd_bank;
  assign pp.Rd_En     = w_issue;
  assign pp.Rd_Addr   = r_addr;
  assign pp.Out_I     = r_fifo_i[r_rd_ptr];
  assign pp.Out_Q     = r_fifo_q[r_rd_ptr];
  assign pp.Out_Valid = w_out_valid;
  assign pp.Out_First = r_fifo_first[r_rd_ptr];
  assign pp.Out_Last  = r_fifo_last[r_rd_ptr];
  assign pp.Busy      = w_busy;
  assign pp.Overrun   = r_overrun;

endmodule
